div_pipeline: RTL and testbench

Fully pipelined unsigned restoring divider, the inverse of the shift-add multiplier pipeline in the same arithmetic library. It accepts one dividend/divisor pair per cycle and returns quotient and remainder after a fixed latency of N cycles. It is built from N identical shift-subtract stage cells, each resolving one quotient bit, MSB first. It sits beside the multiplier in datapaths that need sustained-throughput division.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_if.sv | 22 ++
 rtl/div_cell.sv | 34 +++
 rtl/div_pipeline.sv | 45 ++++
 tb/tb_div_pipeline.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared constants and stage record for the pipelined restoring divider.
// DIV_ZERO_DET_EN adds the per-stage divide-by-zero flag to the record.
package div_pkg;

    localparam int unsigned N = 8;  // dividend/quotient width and pipeline depth
    localparam int unsigned M = 4;  // divisor/remainder width

    typedef struct packed {
        logic         valid;
        logic [M-1:0] rem;
        logic [N-1:0] dvd;
        logic [N-1:0] quo;
        logic [M-1:0] dvs;
`ifdef DIV_ZERO_DET_EN
        logic         dz;
`endif
    } stage_t;

endpackage

// File: rtl/div_if.sv
// Operand/result bundle for div_pipeline.
interface div_if;

    logic                      en;
    logic [div_pkg::N-1:0]     dividend;
    logic [div_pkg::M-1:0]     divisor;
    logic [div_pkg::N-1:0]     quotient;
    logic [div_pkg::M-1:0]     remainder;
    logic                      div_zero;
    logic                      rdy;

    modport master (
        output en, dividend, divisor,
        input  quotient, remainder, div_zero, rdy
    );

    modport slave (
        input  en, dividend, divisor,
        output quotient, remainder, div_zero, rdy
    );

endinterface

// File: rtl/div_cell.sv
// One shift-subtract stage: resolves one quotient bit, MSB first, into a registered record.
module div_cell
    import div_pkg::*;
(
    input  logic   clk,
    input  logic   rstn,
    input  stage_t din,
    output stage_t dout
);

    logic [M:0] trial;
    logic       ge;
    stage_t     nxt;

    // Restoring step: bring in the next dividend bit and subtract if it fits.
    always_comb begin
        trial    = {din.rem, din.dvd[N-1]};
        ge       = (trial >= {1'b0, din.dvs});
        nxt      = din;
        nxt.dvd  = N'({din.dvd, 1'b0});
        nxt.quo  = N'({din.quo, ge});
        nxt.rem  = ge ? M'(trial - {1'b0, din.dvs}) : trial[M-1:0];
    end

    // Bubbles travel as all-zero records so outputs read 0 whenever rdy is low.
    always_ff @(posedge clk) begin
        if (!rstn || !din.valid) begin
            dout <= '0;
        end else begin
            dout <= nxt;
        end
    end

endmodule

// File: rtl/div_pipeline.sv
// Fully pipelined unsigned restoring divider, N-cycle latency, one result per cycle.
// DIV_ZERO_DET_EN enables the div_zero flag; otherwise div_zero is tied to 0.
module div_pipeline
    import div_pkg::*;
(
    input  logic  clk,
    input  logic  rstn,
    div_if.slave  bus
);

    stage_t head;
    stage_t stg [N];
    logic   unused_tail;

    always_comb begin
        head       = '0;
        head.valid = bus.en;
        head.dvd   = bus.dividend;
        head.dvs   = bus.divisor;
`ifdef DIV_ZERO_DET_EN
        head.dz    = (bus.divisor == '0);
`endif
    end

    for (genvar k = 0; k < int'(N); k++) begin : g_stage
        if (k == 0) begin : g_first
            div_cell u_cell (.clk(clk), .rstn(rstn), .din(head),       .dout(stg[k]));
        end else begin : g_next
            div_cell u_cell (.clk(clk), .rstn(rstn), .din(stg[k-1]), .dout(stg[k]));
        end
    end

    assign bus.quotient  = stg[N-1].quo;
    assign bus.remainder = stg[N-1].rem;
    assign bus.rdy       = stg[N-1].valid;
`ifdef DIV_ZERO_DET_EN
    assign bus.div_zero  = stg[N-1].dz;
`else
    assign bus.div_zero  = 1'b0;
`endif

    // Dividend is fully consumed and the divisor copy has no consumer past the last stage.
    assign unused_tail = ^{stg[N-1].dvd, stg[N-1].dvs};

endmodule

// File: tb/tb_div_pipeline.sv
// Self-checking bench for div_pipeline; honours DIV_ZERO_DET_EN for div_zero expectations.
module tb_div_pipeline;
    import div_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    div_if bus ();
    div_pipeline dut (.clk(clk), .rstn(rstn), .bus(bus));

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit           v;
        logic [N-1:0] a;
        logic [M-1:0] b;
        logic [N-1:0] q;
        logic [M-1:0] r;
        bit           z;
    } ent_t;

    ent_t mq[$];
    ent_t expd;

    // Arithmetic reference: what the divider should return for one issued pair.
    function automatic ent_t ref_div(bit v, logic [N-1:0] a, logic [M-1:0] b);
        ent_t e;
        e = '{v: 1'b0, a: '0, b: '0, q: '0, r: '0, z: 1'b0};
        if (v) begin
            e.v = 1'b1; e.a = a; e.b = b;
            if (b == 0) begin
                e.q = '1;
                e.r = M'(a);
            end else begin
                e.q = N'(a / b);
                e.r = M'(a % b);
            end
`ifdef DIV_ZERO_DET_EN
            e.z = (b == 0);
`endif
        end
        return e;
    endfunction

    task automatic flush_model();
        mq.delete();
        for (int i = 0; i < int'(N); i++) mq.push_back(ref_div(1'b0, '0, '0));
    endtask

    // Drive one cycle, advance the latency model, sample 1 time unit after the edge.
    task automatic step(bit r, bit e, logic [N-1:0] a, logic [M-1:0] b);
        rstn         = r;
        bus.en       = e;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        if (!r) flush_model();
        else begin
            mq.push_back(ref_div(e, a, b));
            void'(mq.pop_front());
        end
        expd = mq[0];
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, N'(8'hAA), M'(4'h3));
        tests++;
        if (bus.rdy !== 1'b0 || bus.quotient !== '0 || bus.remainder !== '0 || bus.div_zero !== 1'b0) begin
            fails++;
            $display("FAIL reset: rdy=%0b q=%0d r=%0d dz=%0b, required all 0",
                     bus.rdy, bus.quotient, bus.remainder, bus.div_zero);
        end
    endtask

    task automatic test_single();
        for (int i = 0; i <= int'(N) + 1; i++) begin
            if (i == 0) step(1'b1, 1'b1, N'(100), M'(7));
            else        step(1'b1, 1'b0, N'($urandom), M'($urandom));
            tests++;
            if (i == int'(N) - 1) begin
                if (bus.rdy !== 1'b1 || bus.quotient !== N'(14) || bus.remainder !== M'(2) || bus.div_zero !== 1'b0) begin
                    fails++;
                    $display("FAIL single cyc%0d: rdy=%0b q=%0d r=%0d dz=%0b, required 1 14 2 0",
                             i, bus.rdy, bus.quotient, bus.remainder, bus.div_zero);
                end
            end else if (bus.rdy !== 1'b0 || bus.quotient !== '0 || bus.remainder !== '0) begin
                fails++;
                $display("FAIL single_idle cyc%0d: rdy=%0b q=%0d r=%0d, required 0 0 0",
                         i, bus.rdy, bus.quotient, bus.remainder);
            end
        end
    endtask

    task automatic test_stream();
        logic [N-1:0] a_in [4] = '{N'(255), N'(5), N'(15), N'(0)};
        logic [M-1:0] b_in [4] = '{M'(1),   M'(9), M'(15), M'(3)};
        logic [N-1:0] q_ex [4] = '{N'(255), N'(0), N'(1),  N'(0)};
        logic [M-1:0] r_ex [4] = '{M'(0),   M'(5), M'(0),  M'(0)};
        logic [N-1:0] gq[$];
        logic [M-1:0] gr[$];
        int           gc[$];
        for (int i = 0; i < 4 + int'(N) + 2; i++) begin
            if (i < 4) step(1'b1, 1'b1, a_in[i], b_in[i]);
            else       step(1'b1, 1'b0, '0, '0);
            if (bus.rdy === 1'b1) begin
                gq.push_back(bus.quotient); gr.push_back(bus.remainder); gc.push_back(i);
            end
        end
        tests++;
        if (gq.size() != 4) begin
            fails++;
            $display("FAIL stream_count: got %0d results, required 4", gq.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (gq[k] !== q_ex[k] || gr[k] !== r_ex[k] || gc[k] != int'(N) - 1 + k) begin
                    fails++;
                    $display("FAIL stream%0d: q=%0d r=%0d cyc=%0d, required q=%0d r=%0d cyc=%0d",
                             k, gq[k], gr[k], gc[k], q_ex[k], r_ex[k], int'(N) - 1 + k);
                end
            end
        end
    endtask

    task automatic test_div_zero();
        bit dz_ex;
`ifdef DIV_ZERO_DET_EN
        dz_ex = 1'b1;
`else
        dz_ex = 1'b0;
`endif
        step(1'b1, 1'b1, N'(200), M'(0));
        for (int i = 1; i < int'(N); i++) step(1'b1, 1'b0, '0, '0);
        tests++;
        if (bus.rdy !== 1'b1 || bus.quotient !== N'(255) || bus.remainder !== M'(8) || bus.div_zero !== dz_ex) begin
            fails++;
            $display("FAIL div_zero: rdy=%0b q=%0d r=%0d dz=%0b, required 1 255 8 %0b",
                     bus.rdy, bus.quotient, bus.remainder, bus.div_zero, dz_ex);
        end
        step(1'b1, 1'b0, '0, '0);
        tests++;
        if (bus.rdy !== 1'b0 || bus.div_zero !== 1'b0) begin
            fails++;
            $display("FAIL div_zero_after: rdy=%0b dz=%0b, required 0 0", bus.rdy, bus.div_zero);
        end
    endtask

    task automatic test_bubble();
        logic         ro [4];
        logic [N-1:0] qo [4];
        logic [M-1:0] rr [4];
        for (int i = 0; i < int'(N) + 3; i++) begin
            if (i == 0)      step(1'b1, 1'b1, N'(50), M'(3));
            else if (i == 2) step(1'b1, 1'b1, N'(77), M'(10));
            else             step(1'b1, 1'b0, N'($urandom), M'($urandom));
            if (i >= int'(N) - 1 && i <= int'(N) + 2) begin
                ro[i-int'(N)+1] = bus.rdy; qo[i-int'(N)+1] = bus.quotient; rr[i-int'(N)+1] = bus.remainder;
            end
        end
        tests++;
        if (ro[0] !== 1'b1 || qo[0] !== N'(16) || rr[0] !== M'(2)) begin
            fails++; $display("FAIL bubble_first: rdy=%0b q=%0d r=%0d, required 1 16 2", ro[0], qo[0], rr[0]);
        end
        tests++;
        if (ro[1] !== 1'b0 || qo[1] !== '0 || rr[1] !== '0) begin
            fails++; $display("FAIL bubble_gap: rdy=%0b q=%0d r=%0d, required 0 0 0", ro[1], qo[1], rr[1]);
        end
        tests++;
        if (ro[2] !== 1'b1 || qo[2] !== N'(7) || rr[2] !== M'(7)) begin
            fails++; $display("FAIL bubble_second: rdy=%0b q=%0d r=%0d, required 1 7 7", ro[2], qo[2], rr[2]);
        end
        tests++;
        if (ro[3] !== 1'b0) begin
            fails++; $display("FAIL bubble_tail: rdy=%0b, required 0", ro[3]);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1, N'(100), M'(7));
        step(1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b1, N'(33), M'(4));   // reset edge; this input must be discarded
        for (int i = 0; i < int'(N) + 2; i++) begin
            step(1'b1, 1'b0, N'($urandom), M'($urandom));
            tests++;
            if (bus.rdy !== 1'b0 || bus.quotient !== '0) begin
                fails++;
                $display("FAIL reset_mid_kill cyc%0d: rdy=%0b q=%0d, required 0 0", i, bus.rdy, bus.quotient);
            end
        end
        step(1'b1, 1'b1, N'(9), M'(2));
        for (int i = 1; i < int'(N); i++) step(1'b1, 1'b0, '0, '0);
        tests++;
        if (bus.rdy !== 1'b1 || bus.quotient !== N'(4) || bus.remainder !== M'(1)) begin
            fails++;
            $display("FAIL reset_mid_new: rdy=%0b q=%0d r=%0d, required 1 4 1", bus.rdy, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] a;
        logic [M-1:0] b;
        bit           e;
        for (int i = 0; i < 10000 + int'(N); i++) begin
            e = ($urandom_range(0, 3) != 0) && (i < 10000);
            a = N'($urandom);
            b = M'($urandom);
            if (i == 0) begin a = '1; b = '1; e = 1'b1; end
            if (i == 1) begin a = '1; b = M'(1); e = 1'b1; end
            step(1'b1, e, a, b);
            tests++;
            if (bus.rdy !== expd.v || bus.quotient !== expd.q || bus.remainder !== expd.r || bus.div_zero !== expd.z) begin
                fails++;
                $display("FAIL random cyc%0d: rdy=%0b q=%0d r=%0d dz=%0b, required %0b %0d %0d %0b",
                         i, bus.rdy, bus.quotient, bus.remainder, bus.div_zero, expd.v, expd.q, expd.r, expd.z);
            end
            if (expd.v && expd.b != 0) begin
                tests++;
                if (int'(bus.quotient) * int'(expd.b) + int'(bus.remainder) != int'(expd.a) ||
                    bus.remainder >= expd.b) begin
                    fails++;
                    $display("FAIL random_identity cyc%0d: %0d/%0d gave q=%0d r=%0d",
                             i, expd.a, expd.b, bus.quotient, bus.remainder);
                end
            end
        end
    endtask

    initial begin
        bus.en       = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        flush_model();
        expd = mq[0];
        test_reset();
        test_single();
        test_stream();
        test_div_zero();
        test_bubble();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
